// File: rtl/mult53_arbiter_if.sv
// Requester-side bus of mult53_arbiter: packed per-requester operands,
// one-hot grant, and the tagged result stream returned from the shared core.
interface mult53_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*53-1:0] opa;
  logic [NREQ*53-1:0] opb;
  logic [NREQ-1:0]    ack;
  logic               res_valid;
  logic [2:0]         res_id;
  logic [53:0]        res;
  logic               busy;

  modport master (
    output req, opa, opb,
    input  ack, res_valid, res_id, res, busy
  );

  modport slave (
    input  req, opa, opb,
    output ack, res_valid, res_id, res, busy
  );
endinterface

// File: rtl/mult53_arbiter.sv
// Round-robin arbiter sharing one pipelined Mult53 core among NREQ requesters.
// Optional statistics counters are enabled with `define MULT53_ARB_STATS_EN.

// Pipelined 53x53 core: R is the upper 54 bits of the 106-bit product,
// available LAT edges after the operands are sampled. Deliberately unreset.
module Mult53 #(
  parameter int LAT = 3
) (
  input  logic        i_clk,
  input  logic [52:0] i_a,
  input  logic [52:0] i_b,
  output logic [53:0] o_r
);
  logic [53:0] r_stage [LAT];

  always_ff @(posedge i_clk) begin
    r_stage[0] <= 54'((106'(i_a) * 106'(i_b)) >> 52);
    for (int k = 1; k < LAT; k++) begin
      r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_r = r_stage[LAT-1];
endmodule

module mult53_arbiter #(
  parameter int NREQ    = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mult53_arbiter_if.slave bus
`ifdef MULT53_ARB_STATS_EN
  ,
  input  logic            i_stat_clr,
  output logic [31:0]     o_stat_issue,
  output logic [31:0]     o_stat_stall,
  output logic [31:0]     o_stat_conflict
`endif
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0]   r_outCnt [NREQ];
  logic [2:0]      r_ptr;
  logic [LAT-1:0]  r_vpipe;
  logic [2:0]      r_tpipe [LAT];

  logic [NREQ-1:0] w_retire;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_issue;
  logic            w_grant;
  logic [2:0]      w_gIdx;
  logic [52:0]     w_coreA;
  logic [52:0]     w_coreB;
  logic [53:0]     w_coreR;

  // A slot retiring this cycle is already free, so a requester at MAX_OUT
  // may be re-granted in the same cycle its oldest result returns.
  always_comb begin
    w_retire = '0;
    w_elig   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_retire[i] = r_vpipe[LAT-1] && (r_tpipe[LAT-1] == 3'(i));
      w_elig[i]   = bus.req[i] &&
                    ((r_outCnt[i] - CW'(w_retire[i])) < CW'(MAX_OUT));
    end
  end

  always_comb begin
    w_grant = 1'b0;
    w_gIdx  = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_grant && w_elig[i] && (((int'(r_ptr) + k) % NREQ) == i)) begin
          w_grant = 1'b1;
          w_gIdx  = 3'(i);
        end
      end
    end
    if (i_rst) begin
      w_grant = 1'b0;
    end
  end

  always_comb begin
    w_issue = '0;
    w_coreA = '0;
    w_coreB = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_issue[i] = w_grant && (w_gIdx == 3'(i));
      if (w_issue[i]) begin
        w_coreA = bus.opa[i*53 +: 53];
        w_coreB = bus.opb[i*53 +: 53];
      end
    end
  end

  Mult53 #(.LAT(LAT)) u_core (
    .i_clk (i_clk),
    .i_a   (w_coreA),
    .i_b   (w_coreB),
    .o_r   (w_coreR)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= 3'd0;
      r_vpipe <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_tpipe[k] <= 3'd0;
      end
      for (int i = 0; i < NREQ; i++) begin
        r_outCnt[i] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_ptr <= (w_gIdx == 3'(NREQ - 1)) ? 3'd0 : w_gIdx + 3'd1;
      end
      r_vpipe[0] <= w_grant;
      r_tpipe[0] <= w_gIdx;
      for (int k = 1; k < LAT; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
        r_tpipe[k] <= r_tpipe[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (w_issue[i] && !w_retire[i]) begin
          r_outCnt[i] <= r_outCnt[i] + CW'(1);
        end else if (!w_issue[i] && w_retire[i]) begin
          r_outCnt[i] <= r_outCnt[i] - CW'(1);
        end
      end
    end
  end

  assign bus.ack       = w_issue;
  assign bus.res_valid = r_vpipe[LAT-1];
  assign bus.res_id    = r_tpipe[LAT-1];
  assign bus.res       = w_coreR;
  assign bus.busy      = |r_vpipe;

`ifdef MULT53_ARB_STATS_EN
  logic [31:0] r_statIssue;
  logic [31:0] r_statStall;
  logic [31:0] r_statConflict;
  logic        w_conflict;

  // Two or more eligible bits set: clearing the lowest one leaves a remainder.
  assign w_conflict = (w_elig & (w_elig - NREQ'(1))) != '0;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_stat_clr) begin
      r_statIssue    <= '0;
      r_statStall    <= '0;
      r_statConflict <= '0;
    end else begin
      if (w_grant && (r_statIssue != '1)) begin
        r_statIssue <= r_statIssue + 32'd1;
      end
      if ((|bus.req) && !w_grant && (r_statStall != '1)) begin
        r_statStall <= r_statStall + 32'd1;
      end
      if (w_conflict && (r_statConflict != '1)) begin
        r_statConflict <= r_statConflict + 32'd1;
      end
    end
  end

  assign o_stat_issue    = r_statIssue;
  assign o_stat_stall    = r_statStall;
  assign o_stat_conflict = r_statConflict;
`endif
endmodule
